// File: rtl/obj_pkg.sv
// rtl/obj_pkg.sv - object RAM field layout, scan depth and scan state encodings
package obj_pkg;

  localparam int NUM_OBJ     = 8;
  localparam int OBJ_W       = 13;
  localparam int OBJ_ON      = 12;
  localparam int OBJ_TILE_HI = 11;
  localparam int OBJ_TILE_LO = 9;
  localparam int OBJ_X_HI    = 8;
  localparam int OBJ_X_LO    = 4;
  localparam int OBJ_Y_HI    = 3;
  localparam int OBJ_Y_LO    = 0;

  localparam int TILE_W = OBJ_TILE_HI - OBJ_TILE_LO + 1;
  localparam int X_W    = OBJ_X_HI - OBJ_X_LO + 1;
  localparam int Y_W    = OBJ_Y_HI - OBJ_Y_LO + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_READY = 2'd3
  } scan_state_t;

endpackage

// File: rtl/obj_slot_match.sv
// rtl/obj_slot_match.sv - priority match of buffered line slots against the current X tile
module obj_slot_match
  import obj_pkg::*;
#(
  parameter int LINE_SLOTS = 4
) (
  input  logic [LINE_SLOTS-1:0]        slot_valid,
  input  logic [LINE_SLOTS*X_W-1:0]    slot_x,
  input  logic [LINE_SLOTS*TILE_W-1:0] slot_tile,
  input  logic [X_W-1:0]               x_tile,
  output logic                         hit,
  output logic [TILE_W-1:0]            tile
);

  // Walk from the highest slot down so the lowest-numbered match is written last.
  always_comb begin
    hit  = 1'b0;
    tile = '0;
    for (int i = LINE_SLOTS - 1; i >= 0; i--) begin
      if (slot_valid[i] && (slot_x[i*X_W +: X_W] == x_tile)) begin
        hit  = 1'b1;
        tile = slot_tile[i*TILE_W +: TILE_W];
      end
    end
  end

endmodule

// File: rtl/obj_line_renderer.sv
// rtl/obj_line_renderer.sv - per-line object scan into slots and per-pixel hit lookup
// OBJ_LINE_OVF_FLAG_EN enables the sticky per-frame overflow flag on oOvf.
module obj_line_renderer #(
  parameter int NUM_OBJ    = obj_pkg::NUM_OBJ,
  parameter int LINE_SLOTS = 4,
  parameter int TILE_SHIFT = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       iHS,
  input  logic                       iVS,
  input  logic [9:0]                 iLine,
  input  logic [9:0]                 iX,
  input  logic                       iDE,
  output logic [$clog2(NUM_OBJ)-1:0] oObjRam_rdaddr,
  input  logic [12:0]                iObjRam_q,
  output logic                       oObj_hit,
  output logic [2:0]                 oObj_tile,
  output logic [4:0]                 oObj_u,
  output logic [4:0]                 oObj_v,
  output logic                       oOvf
);
  import obj_pkg::*;

  localparam int AW = $clog2(NUM_OBJ);
  localparam int CW = $clog2(LINE_SLOTS + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_OBJ - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(LINE_SLOTS);

  scan_state_t state, state_next;
  logic [AW-1:0] rdaddr, rdaddr_next;
  logic          hs_prev, vs_prev, hs_edge, vs_edge;
  logic [9:0]    line_q;
  logic [Y_W-1:0] line_y;
  logic [X_W-1:0] x_tile;

  logic [LINE_SLOTS-1:0]        slot_valid;
  logic [LINE_SLOTS*X_W-1:0]    slot_x;
  logic [LINE_SLOTS*TILE_W-1:0] slot_tile;
  logic [CW-1:0]                slot_cnt;

  logic eval, accept, slots_full, ovf_cond;
  logic match_hit;
  logic [TILE_W-1:0] match_tile;

  assign hs_edge = hs_prev & ~iHS;
  assign vs_edge = vs_prev & ~iVS;
  assign line_y  = Y_W'(line_q >> TILE_SHIFT);
  assign x_tile  = X_W'(iX >> TILE_SHIFT);

  // RAM data lags the address by a cycle: nothing to evaluate on the first FETCH
  // cycle, and DRAIN picks up the last entry.
  assign eval = ~hs_edge & (((state == ST_FETCH) && (rdaddr != '0)) || (state == ST_DRAIN));
  assign accept = eval & iObjRam_q[OBJ_ON] &
                  (iObjRam_q[OBJ_Y_HI:OBJ_Y_LO] == line_y);
  assign slots_full = (slot_cnt == FULL_CNT);
  assign ovf_cond   = accept & slots_full;
  assign oObjRam_rdaddr = rdaddr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      rdaddr <= '0;
    end else begin
      state  <= state_next;
      rdaddr <= rdaddr_next;
    end
  end

  always_comb begin
    state_next  = state;
    rdaddr_next = rdaddr;
    if (hs_edge) begin
      state_next  = ST_FETCH;
      rdaddr_next = '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (rdaddr == LAST_ADDR) state_next = ST_DRAIN;
          else                     rdaddr_next = rdaddr + 1'b1;
        end
        ST_DRAIN: state_next = ST_READY;
        default:  state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_prev    <= 1'b0;
      vs_prev    <= 1'b0;
      line_q     <= '0;
      slot_valid <= '0;
      slot_x     <= '0;
      slot_tile  <= '0;
      slot_cnt   <= '0;
    end else begin
      hs_prev <= iHS;
      vs_prev <= iVS;
      if (hs_edge) begin
        line_q     <= iLine;
        slot_valid <= '0;
        slot_cnt   <= '0;
      end else if (accept && !slots_full) begin
        for (int i = 0; i < LINE_SLOTS; i++) begin
          if (slot_cnt == CW'(i)) begin
            slot_valid[i]                <= 1'b1;
            slot_x[i*X_W +: X_W]         <= iObjRam_q[OBJ_X_HI:OBJ_X_LO];
            slot_tile[i*TILE_W +: TILE_W] <= iObjRam_q[OBJ_TILE_HI:OBJ_TILE_LO];
          end
        end
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  obj_slot_match #(
    .LINE_SLOTS(LINE_SLOTS)
  ) u_match (
    .slot_valid(slot_valid),
    .slot_x    (slot_x),
    .slot_tile (slot_tile),
    .x_tile    (x_tile),
    .hit       (match_hit),
    .tile      (match_tile)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      oObj_hit  <= 1'b0;
      oObj_tile <= '0;
      oObj_u    <= '0;
      oObj_v    <= '0;
    end else begin
      oObj_hit  <= (state == ST_READY) & iDE & match_hit;
      oObj_tile <= ((state == ST_READY) & iDE & match_hit) ? match_tile : '0;
      oObj_u    <= iX[4:0];
      oObj_v    <= line_q[4:0];
    end
  end

`ifdef OBJ_LINE_OVF_FLAG_EN
  // Set has priority over the frame-start clear.
  always_ff @(posedge clk) begin
    if (reset)         oOvf <= 1'b0;
    else if (ovf_cond) oOvf <= 1'b1;
    else if (vs_edge)  oOvf <= 1'b0;
  end
`else
  logic unused_ovf;
  assign unused_ovf = &{1'b0, ovf_cond, vs_edge};
  assign oOvf = 1'b0;
`endif

endmodule

// File: doc/obj_line_renderer.md
OBJ_LINE_RENDERER -- requirements
Module: obj_line_renderer

Interface
REQ-001 SHALL have parameter NUM_OBJ, default 8, meaning object RAM entries scanned per line.
REQ-002 SHALL have parameter LINE_SLOTS, default 4, meaning maximum objects buffered per line.
REQ-003 SHALL have parameter TILE_SHIFT, default 5, meaning log2 of tile size in pixels (32x32 tiles).
REQ-004 SHALL have one clock and a reset that is synchronous and active-high: clk  input  1  system/pixel clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 iHS  input  1  horizontal sync; a falling edge starts a line scan.
REQ-007 iVS  input  1  vertical sync; a falling edge marks frame start.
REQ-008 iLine  input  10  pixel row of the line about to be displayed, sampled at the iHS falling edge.
REQ-009 iX  input  10  current pixel column.
REQ-010 iDE  input  1  active-video enable.
REQ-011 oObjRam_rdaddr  output  3  object RAM read address.
REQ-012 iObjRam_q  input  13  object RAM read data, valid 1 cycle after address: bit12 ON, [11:9] tile, [8:4] X tile, [3:0] Y tile.
REQ-013 oObj_hit  output  1  an object covers the current pixel.
REQ-014 oObj_tile  output  3  tile number of the covering object.
REQ-015 oObj_u  output  5  column offset inside the tile (iX[4:0]).
REQ-016 oObj_v  output  5  row offset inside the tile (latched iLine[4:0]).
REQ-017 oOvf  output  1  sticky per-frame line-slot overflow flag.

Function
REQ-018 Edge detection on iHS and iVS SHALL use one registered previous-value flop each; edge = prev high and current low.
REQ-019 Scan FSM SHALL have states IDLE, FETCH, DRAIN, READY; reset enters IDLE.
REQ-020 IDLE/READY -> FETCH on iHS edge: latch iLine, clear all slots, drive rdaddr 0.
REQ-021 FETCH SHALL increment rdaddr each cycle through NUM_OBJ-1, then enter DRAIN; DRAIN evaluates the last datum and enters READY; scan completes NUM_OBJ+1 cycles after the edge.
REQ-022 Each datum SHALL be accepted when bit12=1 and [3:0] equals latched iLine[9:TILE_SHIFT] truncated to 4 bits; accepted entries fill the next free slot in address order.
REQ-023 An accepted entry with all LINE_SLOTS full SHALL be dropped and set the overflow condition.
REQ-024 An iHS edge in FETCH or DRAIN SHALL restart the scan from address 0 with slots cleared.
REQ-025 oObj_hit SHALL be 0 unless the state is READY and iDE=1.
REQ-026 In READY, a slot matches when its X equals iX[9:TILE_SHIFT]; the lowest-numbered matching slot (lowest RAM address) wins.
REQ-027 Outputs oObj_hit/tile/u/v SHALL be registered with exactly 1 cycle latency from iX/iDE; tile=0 when hit=0.
REQ-028 iVS edge SHALL clear oOvf; if overflow occurs in the same cycle, set wins.

Reset
REQ-029 Reset SHALL force state IDLE, all slots invalid, rdaddr 0, oObj_hit 0, oObj_tile 0, oObj_u 0, oObj_v 0, oOvf 0, edge flops 0; reset mid-scan aborts the scan.

Configuration
REQ-030 Macro OBJ_LINE_OVF_FLAG_EN defined: oOvf behaves per REQ-023/028; undefined: oOvf tied 0, overflow entries still dropped silently.

Structure
REQ-031 Shared package obj_pkg SHALL hold object field bit positions (ON=12, TILE 11:9, X 8:4, Y 3:0), NUM_OBJ, and scan state encodings.
REQ-032 One sub-module obj_slot_match (combinational priority match of slots against iX) is natural; FSM and slot registers stay in the top.

Verification
REQ-033 RAM entry0={1,3'd2,5'd3,4'd1}, iLine=40, HS edge, wait 10 cycles, iX=100, iDE=1 -> next cycle hit=1, tile=2, u=4, v=8.
REQ-034 Entries 0 and 1 both at X=3,Y=1, tiles 5 and 6 -> tile=5 (lower address wins).
REQ-035 Six ON entries with Y=2, iLine=64 -> only addresses 0-3 render; oOvf=1; next iVS edge -> oOvf=0.
REQ-036 Entry ON=0 at matching X/Y -> hit=0; iDE=0 over matching X -> hit=0.
REQ-037 Second iHS edge 3 cycles into scan -> rdaddr returns to 0, final slots reflect only the restarted scan.
REQ-038 Assert reset during FETCH -> next cycle all outputs 0 and state IDLE; hit stays 0 until the next completed scan.
